// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package counter_pkg;

   localparam int MODE_SAT  = 0;
   localparam int MODE_WRAP = 1;

   // Unsigned clamp; callers widen to 16 bits, the widest supported counter.
   function automatic logic [15:0] clamp_to_max(
      input logic [15:0] value,
      input logic [15:0] max
   );
      return (value > max) ? max : value;
   endfunction

endpackage

// File: rtl/edge_pulse.sv
// Step qualifier: rising-edge detect or straight pass-through of a request.
module edge_pulse #(
   parameter bit Passthru = 1'b0
) (
   input  logic Clock,
   input  logic Reset,
   input  logic In,
   output logic Pulse
);

   logic hist;

   // History follows the input every cycle, including during reset,
   // so a level held through reset never looks like a new edge.
   always_ff @(posedge Clock) begin
      hist <= In;
   end

   assign Pulse = ~Reset & (Passthru ? In : (In & ~hist));

endmodule

// File: rtl/updown_counter_param.sv
// Up/down counter with load, wrap-or-saturate and edge-qualified steps.
module updown_counter_param
   import counter_pkg::*;
#(
   parameter int WIDTH     = 3,
   parameter int START     = 1,
   parameter int MAX_COUNT = 7,
   parameter int WRAP      = 1,
   parameter int EDGE      = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             Increase,
   input  logic             Decrease,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadValue,
   output logic [WIDTH-1:0] Count,
   output logic             AtMax,
   output logic             AtZero,
   output logic             Rollover
);

   if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("updown_counter_param: WIDTH must be 1..16");
   end
   if (longint'(MAX_COUNT) >= (longint'(1) << WIDTH)) begin : g_bad_max
      $error("updown_counter_param: MAX_COUNT must be < 2**WIDTH");
   end
   if (START > MAX_COUNT || START < 0) begin : g_bad_start
      $error("updown_counter_param: START must be <= MAX_COUNT");
   end

   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
   localparam bit               PASS    = (EDGE == 0);

   logic             up;
   logic             down;
   logic [WIDTH-1:0] nxt;
   logic             nxt_roll;

   edge_pulse #(.Passthru(PASS)) u_inc (
      .Clock (Clock),
      .Reset (Reset),
      .In    (Increase),
      .Pulse (up)
   );

   edge_pulse #(.Passthru(PASS)) u_dec (
      .Clock (Clock),
      .Reset (Reset),
      .In    (Decrease),
      .Pulse (down)
   );

   always_comb begin
      nxt      = Count;
      nxt_roll = 1'b0;
      if (Load) begin
         nxt = WIDTH'(clamp_to_max(16'(LoadValue), 16'(MAX_V)));
      end else if (Enable && (up ^ down)) begin
         if (up) begin
            if (Count == MAX_V) begin
               if (WRAP == MODE_WRAP) begin
                  nxt      = '0;
                  nxt_roll = 1'b1;
               end
            end else begin
               nxt = Count + 1'b1;
            end
         end else begin
            if (Count == '0) begin
               if (WRAP == MODE_WRAP) begin
                  nxt      = MAX_V;
                  nxt_roll = 1'b1;
               end
            end else begin
               nxt = Count - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         Count    <= START_V;
         Rollover <= 1'b0;
      end else begin
         Count    <= nxt;
         Rollover <= nxt_roll;
      end
   end

   assign AtMax  = (Count == MAX_V);
   assign AtZero = (Count == '0);

endmodule
